branch_resolve_ctrl: RTL and testbench

Sequencing controller for the ID-stage branch comparator of the 16-bit pipelined datapath. Holds IF/ID while a `beq`/`bne` waits for forwarded operands, then evaluates X − Y with an internal two's-complement subtractor. Taken/not-taken is derived from the OR-reduction of the difference. On a taken branch the block drives the PC-select, target and one-cycle IF/ID flush, and it keeps a saturating taken-branch counter for debug.

---
 rtl/branch_resolve_ctrl.sv | 127 ++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_ctrl.sv
// ID-stage branch resolution sequencer: waits for forwarded operands, compares
// them by subtraction and issues the taken-branch PC redirect and IF/ID flush.
module branch_resolve_ctrl #(
    parameter int WIDTH    = 16,
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             br_valid,
    input  logic             br_is_bne,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             rs_ready,
    input  logic             rt_ready,
    input  logic [WIDTH-1:0] pc_plus1,
    input  logic [WIDTH-1:0] offset,
    output logic             stall_if_id,
    output logic             flush_if_id,
    output logic             pc_sel,
    output logic [WIDTH-1:0] br_target,
    output logic             br_done,
    output logic             br_taken,
    output logic             hazard_err,
    output logic [CNT_W-1:0] taken_cnt
);

    // state | meaning
    // IDLE  | no branch in flight; accept br_valid
    // WAIT  | branch held, operands not yet forwarded; wait counter running
    // EVAL  | operands latched; compare this cycle, register result
    // DONE  | result pulses visible for exactly one cycle
    typedef enum logic [1:0] {IDLE, WAIT, EVAL, DONE} state_t;

    localparam int WW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    state_t           state, nextState;
    logic [WW-1:0]    waitCnt;
    logic [WIDTH-1:0] opX, opY, diff;
    logic             isBne;
    logic             bothReady, latchOps, clrWait, incWait, timeout;
    logic             neq, evalTaken;

    assign bothReady = rs_ready & rt_ready;

    always_comb begin
        nextState = state;
        latchOps  = 1'b0;
        clrWait   = 1'b0;
        incWait   = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (br_valid) begin
                    if (bothReady) begin
                        latchOps  = 1'b1;
                        nextState = EVAL;
                    end else begin
                        clrWait   = 1'b1;
                        nextState = WAIT;
                    end
                end
            end
            WAIT: begin
                // operands arriving on the last permitted cycle still win over timeout
                if (bothReady) begin
                    latchOps  = 1'b1;
                    nextState = EVAL;
                end else if (waitCnt == WW'(MAX_WAIT - 1)) begin
                    timeout   = 1'b1;
                    nextState = DONE;
                end else begin
                    incWait = 1'b1;
                end
            end
            EVAL:    nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    assign diff      = opX + ~opY + WIDTH'(1);
    assign neq       = |diff;
    assign evalTaken = isBne ? neq : ~neq;

    assign stall_if_id = ((state == IDLE) & br_valid) | (state == WAIT) | (state == EVAL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            waitCnt     <= '0;
            opX         <= '0;
            opY         <= '0;
            isBne       <= 1'b0;
            br_target   <= '0;
            br_done     <= 1'b0;
            br_taken    <= 1'b0;
            pc_sel      <= 1'b0;
            flush_if_id <= 1'b0;
            hazard_err  <= 1'b0;
            taken_cnt   <= '0;
        end else begin
            state <= nextState;
            if (clrWait) begin
                waitCnt <= '0;
            end else if (incWait) begin
                waitCnt <= waitCnt + WW'(1);
            end
            if (latchOps) begin
                opX       <= rs_val;
                opY       <= rt_val;
                isBne     <= br_is_bne;
                br_target <= pc_plus1 + offset;
            end
            // result registers load on entry to DONE so the pulses align with it
            br_done     <= (state == EVAL) | timeout;
            br_taken    <= (state == EVAL) & evalTaken;
            pc_sel      <= (state == EVAL) & evalTaken;
            flush_if_id <= (state == EVAL) & evalTaken;
            hazard_err  <= hazard_err | timeout;
            if ((state == EVAL) && evalTaken && (taken_cnt != '1)) begin
                taken_cnt <= taken_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: scoreboard of expected branch
// resolutions, cycle-accurate stall/pulse checks and reset/saturation scenarios.
module tb_branch_resolve_ctrl;

    localparam int MAXW = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        br_valid = 1'b0;
    logic        br_is_bne = 1'b0;
    logic [15:0] rs_val = '0, rt_val = '0, pc_plus1 = '0, offset = '0;
    logic        rs_ready = 1'b0, rt_ready = 1'b0;
    logic        stall_if_id, flush_if_id, pc_sel, br_done, br_taken, hazard_err;
    logic [15:0] br_target;
    logic [7:0]  taken_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        taken;
        logic [15:0] target;
        logic [7:0]  cnt;
        logic        hazard;
        int          doneCyc;
    } exp_t;

    exp_t        sbq[$];
    logic [7:0]  expCnt = '0;
    logic        expHaz = 1'b0;

    branch_resolve_ctrl #(.WIDTH(16), .MAX_WAIT(MAXW), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .br_valid(br_valid), .br_is_bne(br_is_bne),
        .rs_val(rs_val), .rt_val(rt_val), .rs_ready(rs_ready), .rt_ready(rt_ready),
        .pc_plus1(pc_plus1), .offset(offset), .stall_if_id(stall_if_id),
        .flush_if_id(flush_if_id), .pc_sel(pc_sel), .br_target(br_target),
        .br_done(br_done), .br_taken(br_taken), .hazard_err(hazard_err),
        .taken_cnt(taken_cnt)
    );

    always #5 clk = ~clk;

    // rsLow/rtLow: number of cycles the ready is held low from cycle T; -1 = never ready
    task automatic do_branch(input logic bne, input logic [15:0] x, input logic [15:0] y,
                             input logic [15:0] pc, input logic [15:0] off,
                             input int rsLow, input int rtLow, input string name);
        exp_t        e, got;
        logic [15:0] d;
        int          m;
        logic        done;
        d = x - y;
        m = (rsLow < 0 || rtLow < 0) ? 1000 : ((rsLow > rtLow) ? rsLow : rtLow);
        if (m > MAXW) begin
            e.taken   = 1'b0;
            expHaz    = 1'b1;
            e.doneCyc = MAXW + 1;
        end else begin
            e.taken   = bne ? (d != 16'h0) : (d == 16'h0);
            e.doneCyc = (m == 0) ? 2 : m + 2;
        end
        e.hazard = expHaz;
        if (e.taken && expCnt != 8'hFF) expCnt = expCnt + 8'd1;
        e.cnt    = expCnt;
        e.target = pc + off;
        sbq.push_back(e);
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            br_valid  = 1'b1;
            br_is_bne = bne;
            rs_val    = x;
            rt_val    = y;
            pc_plus1  = pc;
            offset    = off;
            rs_ready  = (rsLow >= 0) && (c >= rsLow);
            rt_ready  = (rtLow >= 0) && (c >= rtLow);
            #1;
            if (br_done === 1'b1) begin
                got  = sbq.pop_front();
                done = 1'b1;
                checks++;
                if (c != got.doneCyc) begin
                    errors++;
                    $display("FAIL %s done_cycle: got %0d want %0d", name, c, got.doneCyc);
                end
                checks++;
                if (br_taken !== got.taken) begin
                    errors++;
                    $display("FAIL %s br_taken: got %b want %b", name, br_taken, got.taken);
                end
                checks++;
                if (pc_sel !== got.taken || flush_if_id !== got.taken) begin
                    errors++;
                    $display("FAIL %s pc_sel/flush: got %b/%b want %b", name, pc_sel, flush_if_id, got.taken);
                end
                checks++;
                if (taken_cnt !== got.cnt) begin
                    errors++;
                    $display("FAIL %s taken_cnt: got %h want %h", name, taken_cnt, got.cnt);
                end
                checks++;
                if (hazard_err !== got.hazard) begin
                    errors++;
                    $display("FAIL %s hazard_err: got %b want %b", name, hazard_err, got.hazard);
                end
                checks++;
                if (stall_if_id !== 1'b0) begin
                    errors++;
                    $display("FAIL %s stall_in_done: got %b want 0", name, stall_if_id);
                end
                if (got.taken) begin
                    checks++;
                    if (br_target !== got.target) begin
                        errors++;
                        $display("FAIL %s br_target: got %h want %h", name, br_target, got.target);
                    end
                end
                br_valid = 1'b0;
                rs_ready = 1'b0;
                rt_ready = 1'b0;
            end else begin
                checks++;
                if (stall_if_id !== 1'b1 || pc_sel !== 1'b0 || flush_if_id !== 1'b0) begin
                    errors++;
                    $display("FAIL %s cycle%0d stall/pc_sel/flush: got %b/%b/%b want 1/0/0",
                             name, c, stall_if_id, pc_sel, flush_if_id);
                end
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s br_done_timeout: got no br_done want one within 40 cycles", name);
            void'(sbq.pop_front());
            br_valid = 1'b0;
        end
    endtask

    task automatic check_reset_values(input string name, input logic expStall);
        checks++;
        if (br_done !== 1'b0 || br_taken !== 1'b0 || pc_sel !== 1'b0 || flush_if_id !== 1'b0) begin
            errors++;
            $display("FAIL %s pulses: got done=%b taken=%b pc_sel=%b flush=%b want all 0",
                     name, br_done, br_taken, pc_sel, flush_if_id);
        end
        checks++;
        if (hazard_err !== 1'b0 || br_target !== 16'h0 || taken_cnt !== 8'h0) begin
            errors++;
            $display("FAIL %s regs: got haz=%b target=%h cnt=%h want 0/0000/00",
                     name, hazard_err, br_target, taken_cnt);
        end
        checks++;
        if (stall_if_id !== expStall) begin
            errors++;
            $display("FAIL %s stall: got %b want %b", name, stall_if_id, expStall);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        check_reset_values("reset", 1'b0);
        br_valid = 1'b1;
        #1;
        check_reset_values("reset_valid", 1'b1);
        br_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            br_valid = 1'b0;
            #1;
            checks++;
            if (br_done !== 1'b0 || stall_if_id !== 1'b0 || pc_sel !== 1'b0 || flush_if_id !== 1'b0) begin
                errors++;
                $display("FAIL idle: got done=%b stall=%b pc_sel=%b flush=%b want all 0",
                         br_done, stall_if_id, pc_sel, flush_if_id);
            end
        end
    endtask

    task automatic test_compare();
        do_branch(1'b1, 16'h1234, 16'h1235, 16'h0010, 16'hFFFC, 0, 0, "bne_neq");
        do_branch(1'b0, 16'h8000, 16'h8000, 16'h0100, 16'h0020, 0, 0, "beq_eq");
        do_branch(1'b1, 16'h0000, 16'h0000, 16'h0200, 16'h0004, 0, 0, "bne_eq");
        do_branch(1'b1, 16'h7FFF, 16'h8000, 16'h0300, 16'h0008, 0, 0, "bne_ovf");
        do_branch(1'b0, 16'hFFFF, 16'h0001, 16'h0400, 16'h0010, 0, 0, "beq_neq");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            logic [15:0] a;
            logic [15:0] b;
            a = 16'($urandom);
            b = (i % 2 == 0) ? a : 16'($urandom);
            do_branch(1'($urandom), a, b, 16'($urandom), 16'($urandom), 0, 0, "b2b");
        end
    endtask

    task automatic test_wait();
        do_branch(1'b1, 16'h0001, 16'h0002, 16'h0500, 16'h0003, 3, 0, "wait_rs3");
        do_branch(1'b0, 16'h00AA, 16'h00AA, 16'h0600, 16'hFFF0, 0, 7, "wait_rt7");
        do_branch(1'b0, 16'h0055, 16'h0055, 16'h0700, 16'h0011, MAXW, 2, "wait_last");
    endtask

    task automatic test_timeout();
        do_branch(1'b0, 16'h0009, 16'h0009, 16'h0800, 16'h0001, 0, -1, "timeout");
        do_branch(1'b1, 16'h0009, 16'h0008, 16'h0900, 16'h0002, 0, 0, "after_timeout");
    endtask

    task automatic test_reset_mid_eval();
        @(negedge clk);
        br_valid  = 1'b1;
        br_is_bne = 1'b0;
        rs_val    = 16'h0;
        rt_val    = 16'h0;
        pc_plus1  = 16'h0005;
        offset    = 16'h0001;
        rs_ready  = 1'b1;
        rt_ready  = 1'b1;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("rst_mid_eval", 1'b1);
        br_valid = 1'b0;
        #1;
        checks++;
        if (stall_if_id !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_eval_stall_idle: got %b want 0", stall_if_id);
        end
        expCnt = 8'h0;
        expHaz = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        do_branch(1'b0, 16'h4321, 16'h4321, 16'h0A00, 16'h0010, 0, 0, "post_reset");
    endtask

    task automatic test_saturate();
        rst = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        expCnt = 8'h0;
        expHaz = 1'b0;
        for (int i = 0; i < 256; i++) begin
            do_branch(1'b1, 16'(i + 1), 16'h0000, 16'($urandom), 16'($urandom), 0, 0, "saturate");
        end
        checks++;
        if (taken_cnt !== 8'hFF) begin
            errors++;
            $display("FAIL saturate_final: got %h want ff", taken_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_compare();
        test_back_to_back();
        test_wait();
        test_timeout();
        test_reset_mid_eval();
        test_idle();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
